t01_board_commit: RTL and testbench

//  Initiator side of the line-clear evaluation handshake.
//  - Owns the settled stack (occupancy + colour) and stamps a landed 4x4 piece into it.
//  - Pulses start_eval and presents the merged board to the line-clear engine.
//  - Waits for eval_complete, then latches the engine's cleared board back as the new stack.
//  - Reports lines cleared per commit and flags illegal (overlap / out-of-bounds) placements.

---
 rtl/t01_board_commit.sv | 175 +++++++++++++++++
 tb/tb_t01_board_commit.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t01_board_commit.sv
// rtl/t01_board_commit.sv - stack owner that stamps landed pieces and runs the line-clear handshake
module t01_board_commit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_board,
  input  logic         commit_valid,
  output logic         commit_ready,
  input  logic [15:0]  piece_shape,
  input  logic [4:0]   piece_row,
  input  logic [3:0]   piece_col,
  input  logic [2:0]   piece_color,
  output logic         start_eval,
  output logic [199:0] eval_board,
  output logic [599:0] eval_color,
  input  logic         eval_complete,
  input  logic [199:0] cleared_board,
  input  logic [599:0] cleared_color,
  input  logic [2:0]   cleared_count,
  output logic [199:0] stack_board,
  output logic [599:0] stack_color,
  output logic         commit_done,
  output logic         commit_error,
  output logic [2:0]   last_lines
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAMP,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      reg_shape;
  logic [4:0]       reg_row;
  logic [3:0]       reg_col;
  logic [2:0]       reg_color;
  logic [CNT_W-1:0] wait_cnt;

  logic             stamp_oob;
  logic             stamp_overlap;
  logic [199:0]     merged_board;
  logic [599:0]     merged_color;
  logic [5:0]       cell_row;
  logic [5:0]       cell_col;
  logic [7:0]       cell_idx;
  logic [9:0]       color_idx;

  assign commit_ready = (state == S_IDLE);

  // Merge the registered piece into the stack; sums are 6 bits wide so a
  // piece hanging past the bottom or right edge is flagged, never wrapped.
  always_comb begin
    stamp_oob     = 1'b0;
    stamp_overlap = 1'b0;
    merged_board  = stack_board;
    merged_color  = stack_color;
    cell_row      = '0;
    cell_col      = '0;
    cell_idx      = '0;
    color_idx     = '0;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        if (reg_shape[4'(py * 4 + px)]) begin
          cell_row = {1'b0, reg_row} + 6'(py);
          cell_col = {2'b00, reg_col} + 6'(px);
          if (cell_row > 6'd19 || cell_col > 6'd9) begin
            stamp_oob = 1'b1;
          end else begin
            cell_idx  = {2'b00, cell_row} * 8'd10 + {2'b00, cell_col};
            color_idx = {2'b00, cell_idx} * 10'd3;
            if (stack_board[cell_idx]) begin
              stamp_overlap = 1'b1;
            end
            merged_board[cell_idx]         = 1'b1;
            merged_color[color_idx +: 3]   = reg_color;
          end
        end
      end
    end
  end

  // Commit sequencer: accept, stamp, request evaluation, wait for the engine
  // (bounded), then adopt the engine's board as the new stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      reg_shape    <= '0;
      reg_row      <= '0;
      reg_col      <= '0;
      reg_color    <= '0;
      wait_cnt     <= '0;
      start_eval   <= 1'b0;
      commit_done  <= 1'b0;
      commit_error <= 1'b0;
      eval_board   <= '0;
      eval_color   <= '0;
      stack_board  <= '0;
      stack_color  <= '0;
      last_lines   <= '0;
    end else begin
      start_eval   <= 1'b0;
      commit_done  <= 1'b0;
      commit_error <= 1'b0;
      if (clear_board) begin
        state       <= S_IDLE;
        reg_shape   <= '0;
        reg_row     <= '0;
        reg_col     <= '0;
        reg_color   <= '0;
        wait_cnt    <= '0;
        eval_board  <= '0;
        eval_color  <= '0;
        stack_board <= '0;
        stack_color <= '0;
        last_lines  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (commit_valid) begin
              reg_shape <= piece_shape;
              reg_row   <= piece_row;
              reg_col   <= piece_col;
              reg_color <= piece_color;
              state     <= S_STAMP;
            end
          end
          S_STAMP: begin
            if (stamp_oob || stamp_overlap) begin
              commit_error <= 1'b1;
              state        <= S_IDLE;
            end else begin
              eval_board <= merged_board;
              eval_color <= merged_color;
              start_eval <= 1'b1;
              state      <= S_REQ;
            end
          end
          S_REQ: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            // A completion in the final counted cycle still wins over the abort.
            if (eval_complete) begin
              stack_board <= cleared_board;
              stack_color <= cleared_color;
              last_lines  <= cleared_count;
              commit_done <= 1'b1;
              state       <= S_DONE;
            end else if (wait_cnt == CNT_LAST) begin
              commit_error <= 1'b1;
              state        <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t01_board_commit.sv
// tb/tb_t01_board_commit.sv - randomized bench with a board-level model of the commit handshake
module tb_t01_board_commit;

  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear_board;
  logic         commit_valid;
  logic         commit_ready;
  logic [15:0]  piece_shape;
  logic [4:0]   piece_row;
  logic [3:0]   piece_col;
  logic [2:0]   piece_color;
  logic         start_eval;
  logic [199:0] eval_board;
  logic [599:0] eval_color;
  logic         eval_complete;
  logic [199:0] cleared_board;
  logic [599:0] cleared_color;
  logic [2:0]   cleared_count;
  logic [199:0] stack_board;
  logic [599:0] stack_color;
  logic         commit_done;
  logic         commit_error;
  logic [2:0]   last_lines;

  t01_board_commit #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_board   (clear_board),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .piece_shape   (piece_shape),
    .piece_row     (piece_row),
    .piece_col     (piece_col),
    .piece_color   (piece_color),
    .start_eval    (start_eval),
    .eval_board    (eval_board),
    .eval_color    (eval_color),
    .eval_complete (eval_complete),
    .cleared_board (cleared_board),
    .cleared_color (cleared_color),
    .cleared_count (cleared_count),
    .stack_board   (stack_board),
    .stack_color   (stack_color),
    .commit_done   (commit_done),
    .commit_error  (commit_error),
    .last_lines    (last_lines)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Board model: grid arrays indexed [row][col]
  bit       m_occ  [20][10];
  bit [2:0] m_clr  [20][10];
  bit       m_eocc [20][10];
  bit [2:0] m_eclr [20][10];
  bit       m_mocc [20][10];
  bit [2:0] m_mclr [20][10];
  int       m_last;
  bit       m_busy, m_fin, m_legal, m_acc_now;
  int       m_acc;
  bit       x_start, x_done, x_err;

  // Engine stand-in
  int           eng_edge = -1;
  logic [199:0] eng_b;
  logic [599:0] eng_c;
  int           eng_n;

  // Requester
  bit          pending;
  logic [15:0] pend_shape;
  int          pend_row, pend_col;
  logic [2:0]  pend_color;
  int          fixed_lat;
  bit          stray_en;
  bit          drive_clear;

  bit seen_start, seen_done, seen_err;
  int start_cyc, done_cyc, err_cyc;

  task automatic check(input string nm, input logic [599:0] act, input logic [599:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        m_occ[r][c] = 0;  m_clr[r][c] = 0;
        m_eocc[r][c] = 0; m_eclr[r][c] = 0;
      end
    m_last = 0; m_busy = 0; m_fin = 0; eng_edge = -1;
  endfunction

  function automatic logic [199:0] pk_occ(input bit sel_eval);
    logic [199:0] v;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        v[r*10+c] = sel_eval ? m_eocc[r][c] : m_occ[r][c];
    return v;
  endfunction

  function automatic logic [599:0] pk_clr(input bit sel_eval);
    logic [599:0] v;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        v[3*(r*10+c) +: 3] = sel_eval ? m_eclr[r][c] : m_clr[r][c];
    return v;
  endfunction

  // Timeline view: relative to the acceptance edge, stamp at +1, window +3..+T+2
  function automatic bit in_window(input int k);
    return m_busy && m_legal && !m_fin && (k - m_acc) >= 3 && (k - m_acc) <= T + 2;
  endfunction

  function automatic void model_update();
    int e, r, c;
    bit oob, ovl;
    cyc++;
    x_start = 0; x_done = 0; x_err = 0; m_acc_now = 0;
    if (!rst_n || clear_board) begin
      model_reset();
      return;
    end
    if (m_fin) begin
      m_fin = 0; m_busy = 0;
    end else if (m_busy) begin
      e = cyc - m_acc;
      if (e == 1) begin
        if (!m_legal) begin
          x_err = 1; m_busy = 0;
        end else begin
          m_eocc = m_mocc; m_eclr = m_mclr; x_start = 1;
        end
      end else if (e >= 3 && e <= T + 2) begin
        if (eval_complete) begin
          for (int rr = 0; rr < 20; rr++)
            for (int cc = 0; cc < 10; cc++) begin
              m_occ[rr][cc] = cleared_board[rr*10+cc];
              m_clr[rr][cc] = cleared_color[3*(rr*10+cc) +: 3];
            end
          m_last = int'(cleared_count);
          x_done = 1; m_fin = 1;
        end else if (e == T + 2) begin
          x_err = 1; m_busy = 0;
        end
      end
    end else if (commit_valid) begin
      m_busy = 1; m_acc = cyc; m_acc_now = 1;
      m_mocc = m_occ; m_mclr = m_clr;
      oob = 0; ovl = 0;
      for (int py = 0; py < 4; py++)
        for (int px = 0; px < 4; px++)
          if (piece_shape[py*4+px]) begin
            r = int'(piece_row) + py;
            c = int'(piece_col) + px;
            if (r > 19 || c > 9) oob = 1;
            else begin
              if (m_occ[r][c]) ovl = 1;
              m_mocc[r][c] = 1;
              m_mclr[r][c] = piece_color;
            end
          end
      m_legal = !oob && !ovl;
    end
  endfunction

  // Engine behaviour: drop full rows, let the rest fall to the bottom
  function automatic void line_clear();
    int dst;
    bit full;
    dst = 19; eng_n = 0; eng_b = '0; eng_c = '0;
    for (int r = 19; r >= 0; r--) begin
      full = 1;
      for (int c = 0; c < 10; c++) if (!m_eocc[r][c]) full = 0;
      if (full) eng_n++;
      else begin
        for (int c = 0; c < 10; c++) begin
          eng_b[dst*10+c] = m_eocc[r][c];
          eng_c[3*(dst*10+c) +: 3] = m_eclr[r][c];
        end
        dst--;
      end
    end
  endfunction

  function automatic logic [199:0] rand200();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [599:0] rand600();
    logic [599:0] v;
    for (int i = 0; i < 75; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  // Compare process: model advances on each edge, outputs checked 1 unit later
  always @(posedge clk) begin
    model_update();
    #1;
    check("ready", commit_ready, !m_busy);
    check("start_eval", start_eval, x_start);
    check("commit_done", commit_done, x_done);
    check("commit_error", commit_error, x_err);
    check("last_lines", last_lines, m_last);
    check("stack_board", stack_board, pk_occ(0));
    check("stack_color", stack_color, pk_clr(0));
    check("eval_board", eval_board, pk_occ(1));
    check("eval_color", eval_color, pk_clr(1));
  end

  task automatic cycle();
    int k1 = cyc + 1;
    commit_valid = pending;
    piece_shape  = pend_shape;
    piece_row    = 5'(pend_row);
    piece_col    = 4'(pend_col);
    piece_color  = pend_color;
    clear_board  = drive_clear;
    if (k1 == eng_edge) begin
      eval_complete = 1'b1;
      cleared_board = eng_b;
      cleared_color = eng_c;
      cleared_count = 3'(eng_n);
    end else begin
      eval_complete = stray_en && !in_window(k1) && ($urandom_range(0, 7) == 0);
      cleared_board = rand200();
      cleared_color = rand600();
      cleared_count = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    @(negedge clk);
    if (m_acc_now) pending = 0;
    if (start_eval)   begin seen_start = 1; start_cyc = cyc + 1; end
    if (commit_done)  begin seen_done  = 1; done_cyc  = cyc + 1; end
    if (commit_error) begin seen_err   = 1; err_cyc   = cyc + 1; end
    if (x_start) begin
      eng_edge = cyc + 2 + ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, T + 2)));
      line_clear();
    end
  endtask

  task automatic set_piece(input logic [15:0] s, input int r, input int c, input logic [2:0] col, input int lat);
    fixed_lat = lat; pend_shape = s; pend_row = r; pend_col = c; pend_color = col;
    pending = 1; seen_start = 0; seen_done = 0; seen_err = 0;
  endtask

  task automatic do_commit(input logic [15:0] s, input int r, input int c, input logic [2:0] col, input int lat);
    int n;
    set_piece(s, r, c, col, lat);
    cycle();
    n = 1;
    while ((pending || m_busy) && n < 60) begin
      cycle();
      n++;
    end
    if (pending || m_busy) begin
      n_checks++;
      $display("FAIL commit_bound: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!seen_start && n < 20) begin
      cycle();
      n++;
    end
    if (!seen_start) begin
      n_checks++;
      $display("FAIL start_bound: no start_eval within 20 cycles, required one");
    end
  endtask

  task automatic new_piece();
    logic [15:0] shapes [8];
    shapes = '{16'h000F, 16'h1111, 16'h0033, 16'h0027, 16'h0036, 16'h0063, 16'h0000, 16'h0000};
    pend_shape = shapes[$urandom_range(0, 7)];
    if (pend_shape == 16'h0000 && $urandom_range(0, 1) == 1) pend_shape = 16'($urandom);
    pend_row   = $urandom_range(0, 20);
    pend_col   = $urandom_range(0, 10);
    pend_color = 3'($urandom_range(0, 7));
    pending    = 1;
  endtask

  initial begin
    rst_n = 1'b0; drive_clear = 0; pending = 0; stray_en = 0; fixed_lat = 0;
    pend_shape = '0; pend_row = 0; pend_col = 0; pend_color = '0;
    commit_valid = 0; clear_board = 0; eval_complete = 0;
    piece_shape = '0; piece_row = '0; piece_col = '0; piece_color = '0;
    cleared_board = '0; cleared_color = '0; cleared_count = '0;
    repeat (3) cycle();
    check("rst_ready", commit_ready, 1);
    check("rst_stack", stack_board, 0);
    check("rst_eval", eval_board, 0);
    check("rst_last", last_lines, 0);
    check("rst_pulses", {start_eval, commit_done, commit_error}, 0);
    rst_n = 1'b1;
    cycle();

    // I piece on empty stack, engine answers in the first WAIT cycle
    do_commit(16'h000F, 19, 0, 3'd5, 0);
    check("i_done_seen", seen_done, 1);
    check("i_done_lat", done_cyc - m_acc, 4);
    check("i_eval_row19", eval_board[190 +: 10], 10'h00F);
    check("i_row19", stack_board[190 +: 10], 10'h00F);
    check("i_color", stack_color[570 +: 12], {4{3'd5}});
    check("i_lines", last_lines, 0);

    // Build row 19 = 3F0, then complete it with an I piece
    drive_clear = 1; cycle(); drive_clear = 0;
    check("clr_stack", stack_board, 0);
    do_commit(16'h000F, 19, 4, 3'd1, 1);
    do_commit(16'h0003, 19, 8, 3'd2, 2);
    check("fill_row19", stack_board[190 +: 10], 10'h3F0);
    do_commit(16'h000F, 19, 0, 3'd4, 3);
    check("lc_done", seen_done, 1);
    check("lc_lines", last_lines, 1);
    check("lc_stack", stack_board, 0);

    // Out of bounds: column overflow and row overflow
    do_commit(16'h000F, 5, 8, 3'd6, 0);
    check("oob_err", seen_err, 1);
    check("oob_lat", err_cyc - m_acc, 2);
    check("oob_nostart", seen_start, 0);
    check("oob_stack", stack_board, 0);
    do_commit(16'h1111, 17, 0, 3'd6, 0);
    check("oob_row_err", seen_err, 1);
    check("oob_row_nostart", seen_start, 0);

    // Overlap with an occupied cell
    do_commit(16'h000F, 19, 0, 3'd5, 0);
    do_commit(16'h0001, 19, 2, 3'd7, 0);
    check("ovl_err", seen_err, 1);
    check("ovl_nostart", seen_start, 0);
    check("ovl_row19", stack_board[190 +: 10], 10'h00F);

    // Empty shape still runs the engine
    do_commit(16'h0000, 0, 0, 3'd1, 0);
    check("empty_start", seen_start, 1);
    check("empty_done", seen_done, 1);
    check("empty_row19", stack_board[190 +: 10], 10'h00F);

    // Engine withheld: abort after T WAIT cycles, late completion ignored
    do_commit(16'h000F, 0, 0, 3'd3, 20);
    check("to_err", seen_err, 1);
    check("to_nodone", seen_done, 0);
    check("to_wait_cycles", err_cyc - start_cyc - 1, T);
    seen_done = 0;
    repeat (25) cycle();
    check("late_ignored", seen_done, 0);
    check("to_row19", stack_board[190 +: 10], 10'h00F);
    check("to_rest", stack_board[189:0], 0);

    // clear_board while waiting on the engine
    set_piece(16'h0033, 0, 0, 3'd2, 20);
    wait_start();
    cycle(); cycle();
    drive_clear = 1; cycle(); drive_clear = 0;
    check("midclr_ready", commit_ready, 1);
    check("midclr_stack", stack_board, 0);
    check("midclr_eval", eval_board, 0);
    repeat (25) cycle();

    // Asynchronous reset while waiting on the engine
    do_commit(16'h0033, 18, 3, 3'd2, 1);
    check("o_rows", stack_board[180 +: 20], {10'h018, 10'h018});
    set_piece(16'h0033, 0, 0, 3'd3, 20);
    wait_start();
    cycle();
    rst_n = 1'b0;
    #1;
    check("arst_ready", commit_ready, 1);
    check("arst_stack", stack_board, 0);
    check("arst_start", start_eval, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Random traffic with random engine latency and stray completions
    stray_en = 1; fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (!pending && $urandom_range(0, 2) == 0) new_piece();
      drive_clear = ($urandom_range(0, 249) == 0);
      cycle();
    end
    drive_clear = 0; stray_en = 0; pending = 0;
    repeat (40) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
